// File: rtl/uart_pkg.sv
// Shared types and data-length decode for the UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2,
      ST_BREAK
   } uart_state_e;

   typedef enum logic [1:0] {
      PAR_EVEN  = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_MARK  = 2'b10,
      PAR_SPACE = 2'b11
   } par_mode_e;

   localparam logic [1:0] LEN_5 = 2'b00;
   localparam logic [1:0] LEN_6 = 2'b01;
   localparam logic [1:0] LEN_7 = 2'b10;
   localparam logic [1:0] LEN_8 = 2'b11;

   // Index of the last data bit: 4..7 for 5..8 bit frames.
   function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
      return {1'b1, bits};
   endfunction

   function automatic logic [7:0] len_mask(input logic [1:0] bits);
      logic [7:0] m;
      case (bits)
         LEN_5:   m = 8'h1f;
         LEN_6:   m = 8'h3f;
         LEN_7:   m = 8'h7f;
         default: m = 8'hff;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with synchronous flush; read data is combinational.
module uart_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) begin
         mem[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frame settings are captured when a byte
// is popped so later cfg changes only affect the following frames.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          cfg_en_i,
   input  logic [DIV_W-1:0]              cfg_div_i,
   input  logic [1:0]                    cfg_bits_i,
   input  logic                          cfg_parity_en_i,
   input  logic [1:0]                    cfg_parity_mode_i,
   input  logic                          cfg_stop_bits_i,
   input  logic                          cfg_break_i,
   input  logic [7:0]                    tx_data_i,
   input  logic                          tx_valid_i,
   output logic                          tx_ready_o,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          tx_done_o
);

   uart_state_e      state_q, state_d;
   logic [DIV_W-1:0] baud_q, baud_d;
   logic [DIV_W-1:0] f_div_q, f_div_d;
   logic [2:0]       bit_q, bit_d;
   logic [2:0]       f_last_q, f_last_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             f_par_en_q, f_par_en_d;
   logic             f_par_q, f_par_d;
   logic             f_stop2_q, f_stop2_d;
   logic             f_brk_q, f_brk_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             pop;
   logic             full;
   logic             empty;
   logic [7:0]       rdata;
   logic [7:0]       pop_bits;
   logic             pop_par;
   logic             bit_end;

   assign tx_ready_o = rstn_i & cfg_en_i & ~full;
   assign busy_o     = (state_q != ST_IDLE) | ~empty;
   assign tx_o       = tx_q;
   assign tx_done_o  = done_q;
   assign bit_end    = (baud_q == f_div_q);

   uart_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .flush_i (~cfg_en_i),
      .push_i  (tx_valid_i & tx_ready_o),
      .wdata_i (tx_data_i),
      .pop_i   (pop),
      .rdata_o (rdata),
      .full_o  (full),
      .empty_o (empty),
      .level_o (fifo_level_o)
   );

   always_comb begin
      pop_bits = rdata & len_mask(cfg_bits_i);
      pop_par  = ^pop_bits;
      unique case (par_mode_e'(cfg_parity_mode_i))
         PAR_EVEN:  pop_par = ^pop_bits;
         PAR_ODD:   pop_par = ~^pop_bits;
         PAR_MARK:  pop_par = 1'b1;
         PAR_SPACE: pop_par = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q + DIV_W'(1);
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      f_div_d    = f_div_q;
      f_last_d   = f_last_q;
      f_par_en_d = f_par_en_q;
      f_par_d    = f_par_q;
      f_stop2_d  = f_stop2_q;
      f_brk_d    = f_brk_q;
      done_d     = 1'b0;
      pop        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (cfg_break_i) begin
               state_d   = ST_BREAK;
               f_div_d   = cfg_div_i;
               f_stop2_d = 1'b0;
               f_brk_d   = 1'b1;
            end else if (!empty) begin
               pop        = 1'b1;
               state_d    = ST_START;
               shreg_d    = rdata;
               f_div_d    = cfg_div_i;
               f_last_d   = last_bit_idx(cfg_bits_i);
               f_par_en_d = cfg_parity_en_i;
               f_par_d    = pop_par;
               f_stop2_d  = cfg_stop_bits_i;
               f_brk_d    = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               baud_d  = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == f_last_q) begin
                  state_d = f_par_en_q ? ST_PARITY : ST_STOP1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = shreg_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP1;
               baud_d  = '0;
            end
         end
         ST_STOP1: begin
            if (bit_end) begin
               baud_d = '0;
               if (f_stop2_q) begin
                  state_d = ST_STOP2;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = ~f_brk_q;
               end
            end
         end
         ST_STOP2: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = ST_IDLE;
               done_d  = ~f_brk_q;
            end
         end
         ST_BREAK: begin
            baud_d = '0;
            if (!cfg_break_i) state_d = ST_STOP1;
         end
         default: state_d = ST_IDLE;
      endcase
      // Disable wins over everything, including a frame in flight.
      if (!cfg_en_i) begin
         state_d = ST_IDLE;
         baud_d  = '0;
         bit_d   = '0;
         pop     = 1'b0;
         done_d  = 1'b0;
      end
   end

   // Line level follows the state being entered so tx_o stays a flop.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_BREAK:  tx_d = 1'b0;
         ST_DATA:   tx_d = shreg_d[0];
         ST_PARITY: tx_d = f_par_d;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         f_div_q    <= '0;
         f_last_q   <= '0;
         f_par_en_q <= 1'b0;
         f_par_q    <= 1'b0;
         f_stop2_q  <= 1'b0;
         f_brk_q    <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         f_div_q    <= f_div_d;
         f_last_q   <= f_last_d;
         f_par_en_q <= f_par_en_d;
         f_par_q    <= f_par_d;
         f_stop2_q  <= f_stop2_d;
         f_brk_q    <= f_brk_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set the transmit FIFO depth in entries; legal values are powers of two, minimum 2.
REQ-002 Parameter DIV_W, default 16, SHALL set the baud divisor width in bits.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rstn_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cfg_en_i  input  1  SHALL be the block enable.
REQ-006 cfg_div_i  input  DIV_W  SHALL be the baud divisor; one bit time = cfg_div_i+1 clocks.
REQ-007 cfg_bits_i  input  2  SHALL select data length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-008 cfg_parity_en_i  input  1  SHALL enable the parity bit.
REQ-009 cfg_parity_mode_i  input  2  SHALL select parity: 00 even, 01 odd, 10 mark (1), 11 space (0).
REQ-010 cfg_stop_bits_i  input  1  SHALL select stop bits: 0=one, 1=two.
REQ-011 cfg_break_i  input  1  SHALL request a line break.
REQ-012 tx_data_i  input  8  SHALL be the write data; unused upper bits are ignored.
REQ-013 tx_valid_i  input  1  SHALL qualify tx_data_i.
REQ-014 tx_ready_o  output  1  SHALL indicate the FIFO accepts a write.
REQ-015 tx_o  output  1  SHALL be the serial line, driven from a flop.
REQ-016 busy_o  output  1  SHALL be high whenever the FSM is not IDLE or the FIFO is non-empty.
REQ-017 fifo_level_o  output  $clog2(FIFO_DEPTH)+1  SHALL be the FIFO occupancy.
REQ-018 tx_done_o  output  1  SHALL pulse one clock when a frame's final stop bit completes.

Function
REQ-019 tx_ready_o SHALL equal cfg_en_i AND (level < FIFO_DEPTH); a write occurs when tx_valid_i AND tx_ready_o.
REQ-020 Simultaneous write and pop SHALL leave the level unchanged; a write to an empty FIFO SHALL be poppable the next cycle, never the same cycle.
REQ-021 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
REQ-022 In IDLE with cfg_en_i high, cfg_break_i low and FIFO non-empty, the FSM SHALL pop one entry, latch the data and all cfg_* fields into frame registers, and enter START; tx_o SHALL go low the following clock.
REQ-023 cfg_* changes after the pop SHALL NOT affect the frame in flight.
REQ-024 Each of START, each DATA bit, PARITY, STOP1, STOP2 SHALL hold tx_o for exactly cfg_div_i+1 clocks; the baud counter resets on every state entry.
REQ-025 DATA SHALL shift out LSB first, for exactly the latched data length, then go to PARITY if parity is enabled, else STOP1.
REQ-026 Parity bit SHALL be XOR of transmitted data bits (even), its inverse (odd), 1 (mark) or 0 (space).
REQ-027 STOP1 SHALL go to STOP2 if two stop bits are latched, else IDLE; STOP2 SHALL go to IDLE; tx_done_o pulses on that exit.
REQ-028 Back-to-back frames SHALL be issued with no idle bit time when the FIFO holds data at the end of the final stop bit (IDLE held one clock).
REQ-029 cfg_break_i sampled high in IDLE SHALL enter BREAK (tx_o=0) and remain until cfg_break_i is low, then enter STOP1 with one-stop-bit behaviour, with no tx_done_o pulse; break requested mid-frame SHALL wait for IDLE.
REQ-030 cfg_div_i=0 SHALL yield one-clock bit times.
REQ-031 cfg_en_i low SHALL, on the next clock, force IDLE, set tx_o=1, flush the FIFO to level 0, and suppress tx_done_o.

Reset
REQ-032 On rstn_i low: FSM IDLE, tx_o=1, tx_ready_o=0, busy_o=0, fifo_level_o=0, tx_done_o=0, baud and bit counters 0, FIFO pointers 0.
REQ-033 Reset mid-frame SHALL abort immediately, asynchronously driving tx_o high; FIFO contents are discarded.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state enum, the parity-mode enum and the data-length decode constants.
REQ-035 The FIFO SHALL be a sub-module uart_sync_fifo (parameter DEPTH, WIDTH=8) with push/pop/full/empty/level.

Verification
REQ-036 div=3, 8N1, write 0xA5 -> tx_o: start 0, bits 1,0,1,0,0,1,0,1, stop 1; each bit 4 clocks; tx_done_o pulse once.
REQ-037 div=1, 7 bits, odd parity, two stop, write 0x55 -> 7 data bits 1,0,1,0,1,0,1, parity 1, two stop bits of 2 clocks each.
REQ-038 DEPTH=8, hold cfg_en_i high, write 9 bytes back-to-back with line busy -> 8 accepted, tx_ready_o low at level 8, all 8 frames sent contiguously in order.
REQ-039 cfg_break_i high 50 clocks in IDLE, div=4 -> tx_o low 50 clocks, then high at least 5 clocks, no tx_done_o.
REQ-040 cfg_en_i dropped mid-DATA with 3 queued -> next clock tx_o=1, level 0, busy_o=0, no tx_done_o.
REQ-041 rstn_i asserted mid-PARITY -> tx_o=1 asynchronously, all outputs at reset values.
